// File: rtl/sa_pkg.sv
// Shared types, encodings and helpers for the systolic-array operand path.
package sa_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Load-port target select encodings
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Ceiling log2, never less than 1 so a bus always has at least one bit
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    while ((32'd1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/operand_buf.sv
// Single write-port register file with a registered, zero-when-idle read port.
module operand_buf
  import sa_pkg::*;
#(
  parameter  int unsigned DEPTH      = 64,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int unsigned AW         = clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array: contents survive reset; callers guarantee in-range addresses
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register returns zero whenever no read is issued
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
    else           r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/operand_feeder.sv
// Operand source for the systolic array: buffers A/B and streams them on request.
module operand_feeder
  import sa_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned M_SIZE     = 4,
  parameter  int unsigned N_SIZE     = 4,
  parameter  int unsigned K_SIZE     = 16,
  localparam int unsigned A_DEPTH    = M_SIZE * K_SIZE,
  localparam int unsigned B_DEPTH    = K_SIZE * N_SIZE,
  localparam int unsigned MAX_DEPTH  = (A_DEPTH > B_DEPTH) ? A_DEPTH : B_DEPTH,
  localparam int unsigned ADDR_W     = clog2(MAX_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start_compute,
  input  logic                  read_data,
  output logic [DATA_WIDTH-1:0] data_in_A,
  output logic [DATA_WIDTH-1:0] data_in_B,
  output logic                  data_valid_out,
  output logic                  loaded,
  output logic                  stream_done,
  output logic                  rd_err,
  output logic                  wr_err
);

  localparam int unsigned A_AW  = clog2(A_DEPTH);
  localparam int unsigned B_AW  = clog2(B_DEPTH);
  localparam int unsigned CNT_W = clog2(MAX_DEPTH + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ADDR_W-1:0]  r_a_ptr;
  logic [ADDR_W-1:0]  r_b_ptr;
  logic [CNT_W-1:0]   r_served;
  logic               r_valid;
  logic               r_done;
  logic               r_rd_err;
  logic               r_wr_err;
  logic               r_a_full;
  logic               r_b_full;
  logic               r_loaded;

  logic               w_start_acc;
  logic               w_serve;
  logic               w_last;
  logic               w_rd_bad;
  logic               w_wr_ok;
  logic               w_wr_bad;
  logic               w_a_we;
  logic               w_b_we;
  logic               w_a_last_wr;
  logic               w_b_last_wr;
  logic [A_AW-1:0]    w_a_waddr;
  logic [B_AW-1:0]    w_b_waddr;
  logic [A_AW-1:0]    w_a_raddr;
  logic [B_AW-1:0]    w_b_raddr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: a restart in STREAM keeps streaming; the final serve returns to READY
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_loaded) w_state_nxt = READY;
      READY:   if (start_compute) w_state_nxt = STREAM;
      STREAM:  if (!start_compute && w_last) w_state_nxt = READY;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state decode of start, serve, error and write-acceptance strobes
  always_comb begin
    w_start_acc = 1'b0;
    w_serve     = 1'b0;
    w_last      = 1'b0;
    w_rd_bad    = 1'b0;
    w_wr_ok     = 1'b0;
    w_wr_bad    = 1'b0;
    case (r_state)
      IDLE: begin
        w_rd_bad = read_data;
        w_wr_ok  = wr_en;
      end
      READY: begin
        w_start_acc = start_compute;
        w_rd_bad    = read_data & ~start_compute;
        w_wr_ok     = wr_en;
      end
      STREAM: begin
        w_start_acc = start_compute;
        w_serve     = read_data & ~start_compute;
        w_last      = w_serve & (r_served == CNT_W'(MAX_DEPTH - 1));
        w_wr_bad    = wr_en;
      end
      default: begin
        w_start_acc = 1'b0;
      end
    endcase
  end

  // Load-port decode: out-of-range indices are dropped before reaching the buffers
  always_comb begin
    w_a_we      = w_wr_ok & (wr_sel == SEL_A) & ({1'b0, wr_addr} < (ADDR_W + 1)'(A_DEPTH));
    w_b_we      = w_wr_ok & (wr_sel == SEL_B) & ({1'b0, wr_addr} < (ADDR_W + 1)'(B_DEPTH));
    w_a_last_wr = w_a_we & (wr_addr == ADDR_W'(A_DEPTH - 1));
    w_b_last_wr = w_b_we & (wr_addr == ADDR_W'(B_DEPTH - 1));
    w_a_waddr   = A_AW'(wr_addr);
    w_b_waddr   = B_AW'(wr_addr);
    w_a_raddr   = A_AW'(r_a_ptr);
    w_b_raddr   = B_AW'(r_b_ptr);
  end

  // Pointers, served count, status pulses and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_ptr  <= '0;
      r_b_ptr  <= '0;
      r_served <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_rd_err <= 1'b0;
      r_wr_err <= 1'b0;
      r_a_full <= 1'b0;
      r_b_full <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_valid <= w_serve;
      r_done  <= w_last;
      if (w_start_acc) begin
        r_a_ptr  <= '0;
        r_b_ptr  <= '0;
        r_served <= '0;
      end else if (w_serve) begin
        r_a_ptr  <= (r_a_ptr == ADDR_W'(A_DEPTH - 1)) ? '0 : r_a_ptr + ADDR_W'(1);
        r_b_ptr  <= (r_b_ptr == ADDR_W'(B_DEPTH - 1)) ? '0 : r_b_ptr + ADDR_W'(1);
        r_served <= r_served + CNT_W'(1);
      end
      if (w_start_acc)   r_rd_err <= 1'b0;
      else if (w_rd_bad) r_rd_err <= 1'b1;
      if (w_wr_bad)    r_wr_err <= 1'b1;
      if (w_a_last_wr) r_a_full <= 1'b1;
      if (w_b_last_wr) r_b_full <= 1'b1;
      r_loaded <= r_a_full & r_b_full;
    end
  end

  operand_buf #(
    .DEPTH      (A_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf_a (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_a_we),
    .i_waddr (w_a_waddr),
    .i_wdata (wr_data),
    .i_re    (w_serve),
    .i_raddr (w_a_raddr),
    .o_rdata (data_in_A)
  );

  operand_buf #(
    .DEPTH      (B_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf_b (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_b_we),
    .i_waddr (w_b_waddr),
    .i_wdata (wr_data),
    .i_re    (w_serve),
    .i_raddr (w_b_raddr),
    .o_rdata (data_in_B)
  );

  assign data_valid_out = r_valid;
  assign stream_done    = r_done;
  assign rd_err         = r_rd_err;
  assign wr_err         = r_wr_err;
  assign loaded         = r_loaded;

endmodule
